pdp11_fetch_unit: RTL and testbench

Instruction fetch stage of the PDP-11 pipeline, sitting directly upstream of the instruction decoder. It owns the fetch program counter and reads 16-bit instruction words from flash memory over a hold-until-ack request interface. Fetched words are buffered, tagged with their PC, in a small prefetch queue. Words are handed to decode over a valid/ready handshake, and the queue is flushed when a taken branch redirects the PC.

---
 rtl/pdp11_fetch_unit_pkg.sv | 16 +
 rtl/pdp11_prefetch_queue.sv | 47 ++++
 rtl/pdp11_fetch_unit.sv | 100 ++++++++++
 tb/tb_pdp11_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_fetch_unit_pkg.sv
// Shared types for the PDP-11 instruction fetch stage: FSM states, queue entry layout, PC stride.
package pdp11_fetch_unit_pkg;

    typedef enum logic {
        FETCH_RUN     = 1'b0,
        FETCH_DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } fetch_entry_t;

    localparam logic [15:0] PC_STEP = 16'd2;

endpackage

// File: rtl/pdp11_prefetch_queue.sv
// Prefetch FIFO of PC-tagged instruction words; push lands on the next edge, head is a combinational read.
// Flush clears all entries and wins over a same-cycle push or pop; the caller guarantees no push when full.
module pdp11_prefetch_queue
    import pdp11_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_entry,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output fetch_entry_t            head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) storage[wr_ptr] <= push_entry;
    end

    // Empty queue presents zeros so decode never sees stale words.
    assign head = (count != '0) ? storage[rd_ptr] : '0;

endmodule

// File: rtl/pdp11_fetch_unit.sv
// PDP-11 fetch stage: owns the fetch PC, issues one hold-until-ack flash request at a time,
// queues PC-tagged words for decode (ack in N -> valid in N+1); redirects flush and may discard an in-flight word.
module pdp11_fetch_unit
    import pdp11_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'o000000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_word,
    output logic [15:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        align_err
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t     state, state_nxt;
    logic [15:0]      fetch_pc, fetch_pc_nxt;
    logic [15:0]      hold_addr, hold_addr_nxt;
    logic             mem_req_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop;
    fetch_entry_t     head, push_entry;

    assign push        = (state == FETCH_RUN) && mem_req && mem_ack && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign push_entry  = '{pc: fetch_pc, word: mem_rdata};
    assign mem_addr    = (state == FETCH_DISCARD) ? hold_addr : fetch_pc;
    assign instr_valid = (count != '0);
    assign instr_word  = head.word;
    assign instr_pc    = head.pc;

    pdp11_prefetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        count_nxt = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        hold_addr_nxt = hold_addr;
        mem_req_nxt   = mem_req;

        if (redirect_valid)
            fetch_pc_nxt = {redirect_pc[15:1], 1'b0};
        else if (push)
            fetch_pc_nxt = fetch_pc + PC_STEP;

        if (mem_req && !mem_ack) begin
            // Request must complete at its original address even if the PC moves.
            mem_req_nxt = 1'b1;
            if (state == FETCH_RUN && redirect_valid) begin
                state_nxt     = FETCH_DISCARD;
                hold_addr_nxt = fetch_pc;
            end
        end else begin
            // Next request is issued only if the post-edge queue still has a free slot for it.
            state_nxt   = FETCH_RUN;
            mem_req_nxt = !halt && (count_nxt < CNT_W'(QUEUE_DEPTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH_RUN;
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
            mem_req   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            hold_addr <= hold_addr_nxt;
            mem_req   <= mem_req_nxt;
            align_err <= redirect_valid && redirect_pc[0];
        end
    end

endmodule

// File: tb/tb_pdp11_fetch_unit.sv
// Directed and random checks of pdp11_fetch_unit against a transaction-level queue model.
module tb_pdp11_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_ack, instr_valid, instr_ready, redirect_valid, halt, align_err;
    logic [15:0] mem_addr, mem_rdata, instr_word, instr_pc, redirect_pc;

    logic        w_mem_req, w_instr_valid, w_align_err;
    logic [15:0] w_mem_addr, w_mem_rdata, w_instr_word, w_instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_q[$];
    logic [15:0] m_pc, m_hold;
    logic        m_discard, m_align;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'o000000) return 16'o012700;
        if (a == 16'o000002) return 16'o000004;
        return (a * 16'd37) ^ 16'h5a3c;
    endfunction

    assign mem_rdata   = mem_fn(mem_addr);
    assign w_mem_rdata = mem_fn(w_mem_addr);

    pdp11_fetch_unit #(.RESET_PC(16'o000000), .QUEUE_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .align_err(align_err)
    );

    pdp11_fetch_unit #(.RESET_PC(16'o177774), .QUEUE_DEPTH(4)) u_wrap (
        .clk(clk), .reset(reset), .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(1'b1),
        .mem_rdata(w_mem_rdata), .instr_valid(w_instr_valid), .instr_ready(1'b1),
        .instr_word(w_instr_word), .instr_pc(w_instr_pc), .redirect_valid(1'b0),
        .redirect_pc(16'h0000), .halt(1'b0), .align_err(w_align_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of model checking: compare outputs, then apply this cycle's events to the model.
    task automatic tick();
        logic [31:0] hd;
        int          sz;
        #2;
        check("align_err", 32'(align_err), 32'(m_align));
        check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            hd = m_q[0];
            check("instr_pc", 32'(instr_pc), 32'(hd[31:16]));
            check("instr_word", 32'(instr_word), 32'(hd[15:0]));
        end
        if (mem_req)
            check("mem_addr", 32'(mem_addr), 32'(m_discard ? m_hold : m_pc));
        m_align = redirect_valid && redirect_pc[0];
        if (redirect_valid) begin
            if (mem_req && !mem_ack) begin
                if (!m_discard) begin
                    m_discard = 1'b1;
                    m_hold    = m_pc;
                end
            end else begin
                m_discard = 1'b0;
            end
            m_q.delete();
            m_pc = {redirect_pc[15:1], 1'b0};
        end else begin
            sz = m_q.size();
            if (instr_valid && instr_ready && sz != 0) void'(m_q.pop_front());
            if (mem_req && mem_ack) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    check("no_overflow", 32'(sz < 4), 32'd1);
                    m_q.push_back({m_pc, mem_fn(m_pc)});
                    m_pc = m_pc + 16'd2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          nreq;
        logic [15:0] last_addr;

        reset = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; halt = 1'b0;
        m_pc = 16'o000000; m_hold = 16'o000000; m_discard = 1'b0; m_align = 1'b0;
        @(posedge clk); #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'o000000);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_word", 32'(instr_word), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        check("rst_wrap_addr", 32'(w_mem_addr), 32'o177774);
        @(posedge clk); #1;

        // Zero-wait fetch with decode always ready.
        reset = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
        tick();
        check("req_after_reset", 32'(mem_req), 32'd1);
        check("wrap_addr0", 32'(w_mem_addr), 32'o177774);
        tick();
        check("first_pc", 32'(instr_pc), 32'o000000);
        check("first_word", 32'(instr_word), 32'o012700);
        check("wrap_addr1", 32'(w_mem_addr), 32'o177776);
        tick();
        check("second_pc", 32'(instr_pc), 32'o000002);
        check("second_word", 32'(instr_word), 32'o000004);
        check("wrap_addr2", 32'(w_mem_addr), 32'o000000);

        // Redirect to 0 to start from an empty queue, then fill it with decode stalled.
        redirect_valid = 1'b1; redirect_pc = 16'o000000;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid_drop", 32'(instr_valid), 32'd0);
        check("redir_req_next", 32'(mem_req), 32'd1);
        check("wrap_addr3", 32'(w_mem_addr), 32'o000002);
        instr_ready = 1'b0;
        nreq = 0; last_addr = 16'hffff;
        for (int i = 0; i < 8; i++) begin
            if (mem_req) begin
                nreq++;
                last_addr = mem_addr;
            end
            tick();
        end
        check("fill_req_count", 32'(nreq), 32'd4);
        check("fill_last_addr", 32'(last_addr), 32'o000006);
        check("fill_req_idle", 32'(mem_req), 32'd0);

        instr_ready = 1'b1; mem_ack = 1'b0;
        repeat (5) tick();
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", 32'(mem_addr), 32'o000010);

        // Redirect while the request at 010 is unacked.
        redirect_valid = 1'b1; redirect_pc = 16'o000100;
        tick();
        redirect_valid = 1'b0;
        check("discard_addr_a", 32'(mem_addr), 32'o000010);
        check("discard_valid", 32'(instr_valid), 32'd0);
        tick();
        check("discard_addr_b", 32'(mem_addr), 32'o000010);
        mem_ack = 1'b1;
        tick();
        check("post_discard_req", 32'(mem_req), 32'd1);
        check("post_discard_addr", 32'(mem_addr), 32'o000100);
        check("post_discard_valid", 32'(instr_valid), 32'd0);
        tick();
        check("post_discard_pc", 32'(instr_pc), 32'o000100);

        // Odd redirect target.
        redirect_valid = 1'b1; redirect_pc = 16'o000101;
        tick();
        redirect_valid = 1'b0;
        check("align_pulse", 32'(align_err), 32'd1);
        check("align_addr", 32'(mem_addr), 32'o000100);
        tick();
        check("align_clear", 32'(align_err), 32'd0);

        // Halt with a request outstanding.
        mem_ack = 1'b0; halt = 1'b1;
        tick();
        check("halt_hold_req", 32'(mem_req), 32'd1);
        check("halt_hold_addr", 32'(mem_addr), 32'o000102);
        mem_ack = 1'b1;
        tick();
        check("halt_req_drop", 32'(mem_req), 32'd0);
        check("halt_queued_pc", 32'(instr_pc), 32'o000102);
        repeat (3) tick();
        check("halt_idle", 32'(mem_req), 32'd0);
        halt = 1'b0;
        tick();
        check("unhalt_req", 32'(mem_req), 32'd1);
        check("unhalt_addr", 32'(mem_addr), 32'o000104);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            mem_ack        = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
            if ($urandom_range(0, 31) == 0) halt = ~halt;
            tick();
        end

        // Reset mid-request drops mem_req without a clock edge.
        redirect_valid = 1'b0; halt = 1'b0; mem_ack = 1'b0; instr_ready = 1'b1;
        repeat (6) tick();
        check("pre_reset_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_req", 32'(mem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
